// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational ALU.
// A request is latched on accept, the ALU works from the latched operands for one
// EXEC cycle, and the registered result is held in RESP until the consumer takes it.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_rd1,
    output logic [WIDTH-1:0] alu_rd2,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_err,
    output logic             resp_id,
    output logic             busy
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_resp_zero;
    logic             r_resp_err;
    logic             r_resp_id;

    logic             w_accept;
    logic             w_grant_id;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: op_legal = 1'b1;
            default:                       op_legal = 1'b0;
        endcase
    endfunction

    // Grant selection: only in IDLE; contention goes to the requester not served last.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        w_accept   = 1'b0;
        w_grant_id = 1'b0;
        req_ready  = 2'b00;
        if (r_state == S_IDLE) begin
            if (req_valid == 2'b11) begin
                w_grant_id = ~r_last_grant;
            end else begin
                w_grant_id = req_valid[1];
            end
            w_accept = |req_valid;
            if (w_accept) begin
                req_ready = w_grant_id ? 2'b10 : 2'b01;
            end
        end
    end

    // Operand mux feeding the capture registers (never the ALU directly).
    always_comb begin
        w_sel_op = w_grant_id ? req1_op : req0_op;
        w_sel_a  = w_grant_id ? req1_a  : req0_a;
        w_sel_b  = w_grant_id ? req1_b  : req0_b;
    end

    // Control FSM plus operand capture and registered response payload.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the reset branch clears every register that is visible at a port, so a
        // reset mid-operation leaves nothing of the in-flight request behind.
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_op         <= OP_AND;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_resp_data  <= '0;
            r_resp_zero  <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_id    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples the
            // pre-edge values regardless of statement order.
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_EXEC;
                        r_op         <= w_sel_op;
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                    end
                end
                S_EXEC: begin
                    r_state   <= S_RESP;
                    r_resp_id <= r_id;
                    if (op_legal(r_op)) begin
                        r_resp_data <= alu_out;
                        r_resp_zero <= alu_zero;
                        r_resp_err  <= 1'b0;
                    end else begin
                        r_resp_data <= '0;
                        r_resp_zero <= 1'b0;
                        r_resp_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_rd1    = r_a;
    assign alu_rd2    = r_b;
    assign alu_op     = r_op;
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign resp_data  = r_resp_data;
    assign resp_zero  = r_resp_zero;
    assign resp_err   = r_resp_err;
    assign resp_id    = r_resp_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed requests with hand-computed results pushed
// into a scoreboard queue; a monitor pops and compares on each response handshake.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] alu_rd1, alu_rd2;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_out;
    logic         alu_zero;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_zero, resp_err, resp_id;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
        logic         err;
        logic         id;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    n_checks = 0;
    int    n_err    = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .alu_rd1(alu_rd1), .alu_rd2(alu_rd2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
        .resp_id(resp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared ALU model; illegal codes produce a nonzero XOR so a leak would show.
    always_comb begin
        case (alu_op)
            4'b0000: alu_out = alu_rd1 & alu_rd2;
            4'b0001: alu_out = alu_rd1 | alu_rd2;
            4'b0010: alu_out = alu_rd1 + alu_rd2;
            4'b0110: alu_out = alu_rd1 - alu_rd2;
            default: alu_out = alu_rd1 ^ alu_rd2;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic push(input logic [W-1:0] d, input logic z, input logic e, input logic id);
        resp_t r;
        r.data = d;
        r.zero = z;
        r.err  = e;
        r.id   = id;
        exp_q.push_back(r);
    endtask

    // Called just after a posedge with requests driven; returns just after the accept edge.
    task automatic wait_accept(input string name, input logic [1:0] exp_ready);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                check(name, 64'(req_ready), 64'(exp_ready));
                @(posedge clk);
                #1;
                return;
            end
        end
        fail_now(name);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !busy) return;
        end
        fail_now(name);
    endtask

    // Scoreboard monitor: a response handshake completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_resp: got data=%h id=%0d expected no response",
                         resp_data, resp_id);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_payload", 64'({resp_data, resp_zero, resp_err, resp_id}), 64'(mon_e));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        req0_op    = 4'b0000; req1_op = 4'b0000;
        req0_a     = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp_ready = 1'b0;

        // Reset state
        #1;
        check("rst_req_ready",  64'(req_ready),  64'h0);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_busy",       64'(busy),       64'h0);
        check("rst_payload",    64'({resp_data, resp_zero, resp_err, resp_id}), 64'h0);
        check("rst_alu",        64'({alu_rd1, alu_rd2, alu_op}), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Req0 ADD 1+1 with latency profile
        @(posedge clk); #1;
        resp_ready = 1'b1;
        req_valid  = 2'b01;
        req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
        wait_accept("add_grant", 2'b01);
        req_valid = 2'b00;
        push(32'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("add_exec_busy", 64'({busy, resp_valid}), 64'b10);
        @(negedge clk);
        check("add_t2_valid", 64'(resp_valid), 64'h1);
        @(negedge clk);
        check("add_back_idle", 64'({busy, resp_valid}), 64'b00);
        wait_drain("add_drain");

        // Req1 SUB 143-1293 wraps
        @(posedge clk); #1;
        req_valid = 2'b10;
        req1_op = 4'b0110; req1_a = 32'd143; req1_b = 32'd1293;
        wait_accept("sub_grant", 2'b10);
        req_valid = 2'b00;
        push(32'hFFFFFB82, 1'b0, 1'b0, 1'b1);
        wait_drain("sub_drain");

        // Contention: last grant was req1, so req0 wins; then req1
        @(posedge clk); #1;
        req_valid = 2'b11;
        req0_op = 4'b0110; req0_a = 32'd5;    req0_b = 32'd5;
        req1_op = 4'b0001; req1_a = 32'h34;   req1_b = 32'h39;
        wait_accept("rr_grant0", 2'b01);
        req_valid = 2'b10;
        req0_a = 32'hDEAD;
        push(32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("rr_exec_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        check("rr_resp_ready_blk", 64'({resp_valid, req_ready}), 64'b100);
        wait_accept("rr_grant1", 2'b10);
        req_valid = 2'b00;
        push(32'h3D, 1'b0, 1'b0, 1'b1);
        wait_drain("rr_drain");

        // Next contention grants req0; stall RESP for 3 cycles with both valid
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 2'b11;
        req0_op = 4'b0000; req0_a = 32'hF0;       req0_b = 32'h3C;
        req1_op = 4'b0010; req1_a = 32'hFFFFFFFF; req1_b = 32'h1;
        wait_accept("stall_grant0", 2'b01);
        push(32'h30, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", 64'({busy, resp_valid, req_ready, resp_data, resp_zero, resp_err, resp_id}),
                  64'({1'b1, 1'b1, 2'b00, 32'h30, 1'b0, 1'b0, 1'b0}));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("stall_resp_no_accept", 64'(req_ready), 64'h0);
        @(negedge clk);
        check("stall_then_req1", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        push(32'h0, 1'b1, 1'b0, 1'b1);
        wait_drain("stall_drain");

        // Illegal op
        @(posedge clk); #1;
        req_valid = 2'b01;
        req0_op = 4'b1111; req0_a = 32'd7; req0_b = 32'd9;
        wait_accept("ill_grant", 2'b01);
        req_valid = 2'b00;
        push(32'd0, 1'b0, 1'b1, 1'b0);
        wait_drain("ill_drain");

        // Reset during EXEC discards the in-flight AND
        @(posedge clk); #1;
        req_valid = 2'b01;
        req0_op = 4'b0000; req0_a = 32'h33; req0_b = 32'h23;
        wait_accept("rstx_grant", 2'b01);
        req_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check("rstx_async", 64'({busy, resp_valid, req_ready, alu_op, alu_rd1, alu_rd2}), 64'h0);
        check("rstx_payload", 64'({resp_data, resp_zero, resp_err, resp_id}), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b11;
        req0_op = 4'b0000; req0_a = 32'h0F; req0_b = 32'hFF;
        req1_op = 4'b0001; req1_a = 32'h1;  req1_b = 32'h2;
        #1;
        check("rstx_lastgrant", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        check("rstx_first_edge", 64'(busy), 64'h1);
        req_valid = 2'b00;
        push(32'h0F, 1'b0, 1'b0, 1'b0);
        wait_drain("rstx_drain");
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; request i accepted at rising edge where req_valid[i] & req_ready[i].
REQ-006 req0_op, req1_op  input  4 each  ALU operation code per requester.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands per requester.
REQ-008 alu_rd1, alu_rd2  output  WIDTH each  operands driven to shared ALU.
REQ-009 alu_op  output  4  operation driven to shared ALU.
REQ-010 alu_out  input  WIDTH  combinational ALU result; alu_zero  input  1  ALU zero flag.
REQ-011 resp_valid  output  1  response valid; resp_ready  input  1  consumer accept.
REQ-012 resp_data  output  WIDTH  result; resp_zero  output  1  zero flag; resp_err  output  1  illegal op; resp_id  output  1  requester index.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Legal op codes: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110; all others illegal.
REQ-015 FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept; EXEC->RESP unconditionally after one cycle; RESP->IDLE at edge where resp_ready=1; RESP holds otherwise.
REQ-016 req_ready nonzero only in IDLE; at most one bit set; set only for the granted requester with req_valid high.
REQ-017 Grant in IDLE: only one valid -> that requester; both valid -> requester other than last_grant (round-robin).
REQ-018 last_grant register updates to accepted index on accept; resets to 1 (requester 0 wins first contention).
REQ-019 On accept, op, a, b and index of granted requester latched into internal registers; requester inputs ignored thereafter until next IDLE.
REQ-020 alu_rd1, alu_rd2, alu_op driven solely from latched registers (never combinationally from req inputs); hold value outside EXEC.
REQ-021 At EXEC->RESP edge: resp_data <= alu_out, resp_zero <= alu_zero, resp_err <= 0, resp_id <= latched index.
REQ-022 Illegal op: still passes through EXEC; at EXEC->RESP edge resp_data <= 0, resp_zero <= 0, resp_err <= 1.
REQ-023 resp_valid = (state==RESP); resp_data/resp_zero/resp_err/resp_id stable while resp_valid=1 and resp_ready=0.
REQ-024 Latency: accept at edge T -> EXEC in cycle T+1 -> resp_valid high in cycle T+2; max throughput one op per 3 cycles.
REQ-025 No new request accepted during RESP, even when resp_ready=1 in that cycle; acceptance resumes in IDLE next cycle.
REQ-026 Arithmetic wraps modulo 2^WIDTH; no overflow/carry reported.
REQ-027 req_valid dropping before acceptance: no effect, no state change; requester is not held granted.

Reset
REQ-028 rst=1 immediately forces: state IDLE, req_ready 0, resp_valid 0, resp_data 0, resp_zero 0, resp_err 0, resp_id 0, busy 0, alu_rd1 0, alu_rd2 0, alu_op 4'b0000, last_grant 1.
REQ-029 Reset mid-EXEC or mid-RESP discards in-flight operation; no response for it after reset release.
REQ-030 First accept possible at first rising edge with rst=0.

Verification
REQ-031 Req0 ADD a=1 b=1, resp_ready=1 -> resp_valid cycle T+2, resp_data 2, resp_zero 0, resp_err 0, resp_id 0.
REQ-032 Both valid same cycle: req0 SUB 5-5, req1 OR 0x34|0x39 -> req0 served first (data 0, zero 1, id 0), then req1 (data 0x3D, id 1); next contention grants req0.
REQ-033 Req1 SUB 143-1293 -> resp_data 0xFFFFFB82, resp_zero 0, id 1.
REQ-034 resp_ready held 0 for 3 cycles in RESP with both req_valid high -> resp_valid and payload stable, req_ready 2'b00, busy 1.
REQ-035 Req0 op 4'b1111 a=7 b=9 -> resp_err 1, resp_data 0, resp_zero 0.
REQ-036 rst pulsed during EXEC of AND 0x33&0x23 -> outputs reset asynchronously, resp_valid never asserts for that op.
